// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM states, store size codes and lane helpers for the cache controller
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_WRITE_MEM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_t;

    // Byte strobes for a store of the given size at the given byte offset
    function automatic logic [3:0] lane_strb(mem_size_t size, logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data moved onto its byte lanes, unused lanes zero
    function automatic logic [31:0] lane_data(mem_size_t size, logic [1:0] off, logic [31:0] d);
        case (size)
            SZ_BYTE: return {24'h0, d[7:0]} << {off, 3'b000};
            SZ_HALF: return {16'h0, d[15:0]} << {off, 3'b000};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - main-memory bus between the cache controller and memory
interface cache_controller_if #(
    parameter int MEM_AW = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/cache_data_ram.sv
// rtl/cache_data_ram.sv - cache data array, one byte-enabled write port, asynchronous read
module cache_data_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [3:0][7:0] mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through cache with line refill and store forwarding
module cache_controller
    import cache_pkg::*;
#(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_AW         = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          MemWrite,
    input  logic                MemtoReg,
    input  logic [MEM_AW+1:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                stall,
    output logic                misalign,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt,
    cache_controller_if.master  mem
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TB = MEM_AW - WB - IB;

    logic [1:0]    off;
    logic [WB-1:0] word;
    logic [IB-1:0] index;
    logic [TB-1:0] tag;

    assign off   = addr[1:0];
    assign word  = addr[2 +: WB];
    assign index = addr[2+WB +: IB];
    assign tag   = addr[MEM_AW+1 -: TB];

    state_t        state, state_nx;
    logic [LINES-1:0] valid;
    logic [TB-1:0] tag_array [LINES];
    logic [WB-1:0] beat;
    logic          refill_done;   // held load completes this IDLE cycle; do not count it as a hit

    mem_size_t     size;
    logic          hit, is_store, is_mis, refill_last;
    logic [3:0]    strb;
    logic [31:0]   shifted;
    logic          hit_inc, miss_inc;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [IB+WB-1:0] ram_waddr;
    logic [31:0]   ram_wdata;

    assign size        = mem_size_t'(MemWrite);
    assign hit         = valid[index] && (tag_array[index] == tag);
    assign is_store    = (size != SZ_NONE);
    assign is_mis      = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    assign strb        = lane_strb(size, off);
    assign shifted     = lane_data(size, off, wdata);
    assign refill_last = (state == ST_REFILL) && mem.mem_ready && (&beat);

    // Next state, handshake outputs and data-array write selection
    always_comb begin
        state_nx       = state;
        stall          = 1'b0;
        misalign       = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = addr[MEM_AW+1:2];
        mem.mem_wdata  = shifted;
        mem.mem_wstrb  = 4'b0000;
        ram_we         = 1'b0;
        ram_be         = strb;
        ram_waddr      = {index, word};
        ram_wdata      = shifted;
        case (state)
            ST_IDLE: begin
                if (is_store) begin
                    if (is_mis) begin
                        misalign = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_nx = ST_WRITE_MEM;
                    end
                end else if (MemtoReg) begin
                    if (hit) begin
                        hit_inc = ~refill_done;
                    end else begin
                        stall    = 1'b1;
                        miss_inc = 1'b1;
                        state_nx = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {tag, index, beat};
                stall        = 1'b1;
                if (mem.mem_ready) begin
                    ram_we    = 1'b1;
                    ram_be    = 4'b1111;
                    ram_waddr = {index, beat};
                    ram_wdata = mem.mem_rdata;
                    if (&beat) state_nx = ST_IDLE;
                end
            end
            ST_WRITE_MEM: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_wstrb = strb;
                stall         = ~mem.mem_ready;
                if (mem.mem_ready) begin
                    ram_we   = hit;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Refill beat counter, line valid bits and refill-complete marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat        <= '0;
            valid       <= '0;
            refill_done <= 1'b0;
        end else begin
            refill_done <= refill_last;
            if (state == ST_IDLE)                        beat <= '0;
            else if (state == ST_REFILL && mem.mem_ready) beat <= beat + 1'b1;
            if (refill_last) valid[index] <= 1'b1;
        end
    end

    // Tag array is not reset; valid bits guard it
    always_ff @(posedge clk) begin
        if (refill_last) tag_array[index] <= tag;
    end

    // Saturating load hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (miss_inc && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end

    cache_data_ram #(.DEPTH(LINES * WORDS_PER_LINE)) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({index, word}),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller with memory and cache reference model
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  MemWrite;
    logic        MemtoReg;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    cache_controller_if #(.MEM_AW(10)) mif ();

    cache_controller #(.LINES(8), .WORDS_PER_LINE(4), .MEM_AW(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemWrite (MemWrite),
        .MemtoReg (MemtoReg),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .misalign (misalign),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    // slave_mem is the memory as the DUT writes it; ref_mem is what the program semantics say it holds
    logic [31:0] slave_mem [1024];
    logic [31:0] ref_mem   [1024];
    bit          m_valid   [8];
    logic [4:0]  m_tag     [8];
    int          m_hit, m_miss;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic do_load(input logic [11:0] a, output logic [31:0] rd);
        logic [2:0] idx;
        logic [4:0] tg;
        bit         eh;
        int         beats;
        int         guard;
        idx = a[6:4];
        tg  = a[11:7];
        eh  = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        MemWrite = 2'd0; MemtoReg = 1'b1; addr = a;
        #1;
        chk({31'd0, stall}, {31'd0, !eh}, "ld_first_stall");
        if (!eh) begin
            if (m_miss < 65535) m_miss++;
            @(posedge clk);
            beats = 0;
            guard = 0;
            while (beats < 4 && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
                if (mif.mem_req) begin
                    chk({22'd0, mif.mem_addr}, {22'd0, tg, idx, beats[1:0]}, "refill_addr");
                    chk({31'd0, mif.mem_we}, 32'd0, "refill_we");
                    chk({31'd0, stall}, 32'd1, "refill_stall");
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = slave_mem[mif.mem_addr];
                    beats++;
                end else begin
                    mif.mem_ready = 1'b0;
                end
            end
            chk(beats, 4, "refill_beats");
            @(negedge clk);
            mif.mem_ready = 1'b0;
            mif.mem_rdata = 32'd0;
            #1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end else begin
            if (m_hit < 65535) m_hit++;
        end
        chk({31'd0, stall}, 32'd0, "ld_done_stall");
        chk(rdata, ref_mem[a[11:2]], "ld_rdata");
        rd = rdata;
        @(negedge clk);
        MemtoReg = 1'b0;
        #1;
        chk({16'd0, hit_cnt}, m_hit, "hit_cnt");
        chk({16'd0, miss_cnt}, m_miss, "miss_cnt");
    endtask

    task automatic do_store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d, input int rdly);
        logic [1:0]  off;
        bit          mis;
        logic [3:0]  es;
        logic [31:0] ed;
        int          waits;
        int          guard;
        bit          done;
        off = a[1:0];
        mis = (sz == 2'd2 && off[0]) || (sz == 2'd3 && off != 2'd0);
        case (sz)
            2'd1:    begin es = 4'b0001 << off; ed = (d & 32'h0000_00FF) << (8 * off); end
            2'd2:    begin es = 4'b0011 << off; ed = (d & 32'h0000_FFFF) << (8 * off); end
            default: begin es = 4'b1111;        ed = d; end
        endcase
        @(negedge clk);
        MemWrite = sz; MemtoReg = 1'($urandom_range(0, 1)); addr = a; wdata = d;
        #1;
        chk({31'd0, misalign}, {31'd0, mis}, "st_misalign");
        if (mis) begin
            chk({31'd0, stall}, 32'd0, "mis_stall");
            chk({31'd0, mif.mem_req}, 32'd0, "mis_req");
        end else begin
            chk({31'd0, stall}, 32'd1, "st_idle_stall");
            @(posedge clk);
            waits = 0;
            guard = 0;
            done  = 1'b0;
            while (!done && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
                chk({31'd0, mif.mem_req}, 32'd1, "wr_req");
                chk({31'd0, mif.mem_we}, 32'd1, "wr_we");
                chk({22'd0, mif.mem_addr}, {22'd0, a[11:2]}, "wr_addr");
                chk({28'd0, mif.mem_wstrb}, {28'd0, es}, "wr_strb");
                chk(mif.mem_wdata, ed, "wr_data");
                if (waits < rdly) begin
                    mif.mem_ready = 1'b0;
                    #1;
                    chk({31'd0, stall}, 32'd1, "wr_wait_stall");
                    waits++;
                end else begin
                    mif.mem_ready = 1'b1;
                    #1;
                    chk({31'd0, stall}, 32'd0, "wr_ready_stall");
                    for (int i = 0; i < 4; i++) begin
                        if (mif.mem_wstrb[i]) slave_mem[mif.mem_addr][8*i +: 8] = mif.mem_wdata[8*i +: 8];
                        if (es[i])            ref_mem[a[11:2]][8*i +: 8]        = ed[8*i +: 8];
                    end
                    done = 1'b1;
                end
            end
            chk({31'd0, done}, 32'd1, "wr_done");
        end
        @(negedge clk);
        MemWrite = 2'd0; MemtoReg = 1'b0; mif.mem_ready = 1'b0;
        #1;
        chk({16'd0, hit_cnt}, m_hit, "st_hit_cnt");
        chk({16'd0, miss_cnt}, m_miss, "st_miss_cnt");
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] old;
        logic [11:0] a;
        int          op;
        rst_n = 1'b0;
        MemWrite = 2'd0; MemtoReg = 1'b0; addr = 12'd0; wdata = 32'd0;
        mif.mem_ready = 1'b0; mif.mem_rdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk({16'd0, hit_cnt}, 32'd0, "rst_hit_cnt");
        chk({16'd0, miss_cnt}, 32'd0, "rst_miss_cnt");
        chk({31'd0, mif.mem_req}, 32'd0, "rst_req");
        chk({31'd0, stall}, 32'd0, "rst_stall");
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, then hit on the same line
        do_load(12'h040, rd);
        do_load(12'h044, rd);
        chk({16'd0, hit_cnt}, 32'd1, "first_hit_cnt");

        // Byte store to a cached line changes only byte 1
        old = ref_mem[10'h011];
        do_store(12'h045, 2'd1, 32'h0000_00AB, 0);
        do_load(12'h044, rd);
        chk(rd, {old[31:16], 8'hAB, old[7:0]}, "byte1_only");

        // Misaligned half store has no memory effect
        do_store(12'h047, 2'd2, 32'h0000_1234, 0);

        // Store with memory not ready for three cycles
        do_store(12'h048, 2'd3, 32'hDEAD_BEEF, 3);
        do_load(12'h048, rd);

        // Reset in the middle of a refill abandons it
        a = 12'h1C0;
        @(negedge clk);
        MemtoReg = 1'b1; addr = a;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mif.mem_ready = 1'b1;
            mif.mem_rdata = slave_mem[mif.mem_addr];
        end
        @(negedge clk);
        mif.mem_ready = 1'b0;
        #1;
        chk({31'd0, mif.mem_req}, 32'd1, "pre_reset_req");
        rst_n = 1'b0;
        #1;
        chk({31'd0, mif.mem_req}, 32'd0, "reset_req_drop");
        chk({16'd0, miss_cnt}, 32'd0, "reset_miss_cnt");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; MemtoReg = 1'b0;
        do_load(a, rd);
        chk({16'd0, miss_cnt}, 32'd1, "remiss_after_reset");

        // Randomized mix over a few aliasing tags
        for (int n = 0; n < 80; n++) begin
            a  = {5'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom)};
            op = $urandom_range(0, 9);
            if (op < 6) do_load(a, rd);
            else        do_store(a, 2'($urandom_range(1, 3)), $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
